// File: rtl/tj_trig_seq_gen_if.sv
// Trigger-word stream bus between tj_trig_seq_gen and its consumer.
//   out_valid  word on out_data is valid (producer -> consumer)
//   out_ready  consumer accepts when out_valid & out_ready (consumer -> producer)
//   out_data   128-bit trigger word (producer -> consumer)
//   seq_idx    position 0..3 of the word within the sequence (producer -> consumer)
interface tj_trig_seq_gen_if;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [1:0]   seq_idx;

    modport master (
        output out_valid,
        output out_data,
        output seq_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  seq_idx,
        output out_ready
    );
endinterface

// File: rtl/tj_trig_seq_gen.sv
// Trigger word sequence generator: drives W0..W3 (optionally repeated) on a
// valid/ready stream so the plaintext trigger detector can be armed or probed
// with fixed words, fixed order and known timing.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start_i    begin a run (only honoured in IDLE)
//   rep_cnt_i  repetitions of W0..W3, latched at start; 0 behaves as 1
//   abort_i    cancel the run, no done pulse
//   bus        stream master (out_valid/out_data/seq_idx out, out_ready in)
//   busy_o     high while in SEND or GAP
//   done_o     one-cycle pulse after the final word is accepted
//
// States:
//   IDLE | waiting for start
//   SEND | word presented with out_valid=1
//   GAP  | valid-low spacing between accepted words
//   DONE | one-cycle done pulse, then IDLE
module tj_trig_seq_gen #(
    parameter int unsigned GAP = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [7:0]                rep_cnt_i,
    input  logic                      abort_i,
    tj_trig_seq_gen_if.master         bus,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam logic [127:0] W0 = 128'h3243f6a8_885a308d_313198a2_e0370734;
    localparam logic [127:0] W1 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] W2 = 128'h0;
    localparam logic [127:0] W3 = 128'h1;
    localparam logic [7:0]   GAP_C = 8'(GAP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   rep_left_q, rep_left_d;
    logic [7:0]   gap_cnt_q, gap_cnt_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q, out_data_d;
    logic [1:0]   seq_idx_q, seq_idx_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         hs;
    logic         last_word;
    logic [1:0]   idx_nxt;

    function automatic logic [127:0] word_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return W0;
            2'd1:    return W1;
            2'd2:    return W2;
            default: return W3;
        endcase
    endfunction

    assign hs        = out_valid_q & bus.out_ready;
    assign last_word = (seq_idx_q == 2'd3) && (rep_left_q == 8'd1);
    assign idx_nxt   = seq_idx_q + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rep_left_q  <= 8'd0;
            gap_cnt_q   <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 128'd0;
            seq_idx_q   <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rep_left_q  <= rep_left_d;
            gap_cnt_q   <= gap_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            seq_idx_q   <= seq_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) state_d = S_SEND;
                S_SEND: begin
                    if (hs) begin
                        if (last_word)       state_d = S_DONE;
                        else if (GAP_C != 0) state_d = S_GAP;
                    end
                end
                S_GAP:  if (gap_cnt_q == 8'd1) state_d = S_SEND;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Computes next values of the registered outputs and counters.
    always_comb begin
        rep_left_d  = rep_left_q;
        gap_cnt_d   = gap_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        seq_idx_d   = seq_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        if (abort_i) begin
            // out_data deliberately keeps its last word
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            seq_idx_d   = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rep_left_d  = (rep_cnt_i == 8'd0) ? 8'd1 : rep_cnt_i;
                        seq_idx_d   = 2'd0;
                        out_data_d  = W0;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
                S_SEND: begin
                    if (hs) begin
                        if (seq_idx_q == 2'd3) rep_left_d = rep_left_q - 8'd1;
                        if (last_word) begin
                            out_valid_d = 1'b0;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                        end else if (GAP_C == 0) begin
                            seq_idx_d  = idx_nxt;
                            out_data_d = word_of(idx_nxt);
                        end else begin
                            out_valid_d = 1'b0;
                            gap_cnt_d   = GAP_C;
                        end
                    end
                end
                S_GAP: begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                    // seq_idx still names the word just accepted until the reload
                    if (gap_cnt_q == 8'd1) begin
                        seq_idx_d   = idx_nxt;
                        out_data_d  = word_of(idx_nxt);
                        out_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.seq_idx   = seq_idx_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_tj_trig_seq_gen.sv
module tb_tj_trig_seq_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, abort0 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
    logic [7:0] rep0 = 8'd1, rep2 = 8'd2;
    logic busy0, done0, busy2, done2;
    int total = 0;
    int bad = 0;
    logic [127:0] W [4];

    always #5 clk = ~clk;

    tj_trig_seq_gen_if bus0 ();
    tj_trig_seq_gen_if bus2 ();

    tj_trig_seq_gen #(.GAP(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start0), .rep_cnt_i(rep0), .abort_i(abort0),
        .bus(bus0), .busy_o(busy0), .done_o(done0)
    );

    tj_trig_seq_gen #(.GAP(2)) dut2 (
        .clk(clk), .rst(rst), .start_i(start2), .rep_cnt_i(rep2), .abort_i(abort2),
        .bus(bus2), .busy_o(busy2), .done_o(done2)
    );

    // Reference 4-state plaintext trigger detector watching dut0's accepted words.
    logic det_clr = 1'b1;
    int   det_state = 0;
    logic det_fired = 1'b0;
    always @(posedge clk) begin
        if (det_clr) begin
            det_state <= 0;
            det_fired <= 1'b0;
        end else if (bus0.out_valid && bus0.out_ready) begin
            if (bus0.out_data == W[det_state]) begin
                if (det_state == 3) begin
                    det_fired <= 1'b1;
                    det_state <= 0;
                end else begin
                    det_state <= det_state + 1;
                end
            end else begin
                det_state <= (bus0.out_data == W[0]) ? 1 : 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++;
        if ({bus0.out_valid, bus0.seq_idx, busy0, done0} !== 5'b0 || bus0.out_data !== 128'd0) begin
            bad++;
            $display("FAIL reset0 got v=%b i=%0d b=%b d=%b data=%h exp all zero",
                     bus0.out_valid, bus0.seq_idx, busy0, done0, bus0.out_data);
        end
        total++;
        if ({bus2.out_valid, bus2.seq_idx, busy2, done2} !== 5'b0 || bus2.out_data !== 128'd0) begin
            bad++;
            $display("FAIL reset2 got v=%b i=%0d b=%b d=%b data=%h exp all zero",
                     bus2.out_valid, bus2.seq_idx, busy2, done2, bus2.out_data);
        end
    endtask

    // Single pass at full rate; also checks the downstream detector fires.
    task automatic test_single_pass();
        det_clr = 1'b0;
        bus0.out_ready = 1'b1;
        rep0 = 8'd1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({bus0.out_valid, bus0.seq_idx, busy0, done0} !== {1'b1, 2'(i), 1'b1, 1'b0}
                || bus0.out_data !== W[i]) begin
                bad++;
                $display("FAIL t1_word%0d got v=%b i=%0d b=%b d=%b data=%h exp v=1 i=%0d b=1 d=0 data=%h",
                         i, bus0.out_valid, bus0.seq_idx, busy0, done0, bus0.out_data, i, W[i]);
            end
            @(negedge clk);
        end
        total++;
        if ({bus0.out_valid, busy0, done0} !== 3'b001) begin
            bad++;
            $display("FAIL t1_done got v=%b b=%b d=%b exp v=0 b=0 d=1", bus0.out_valid, busy0, done0);
        end
        @(negedge clk);
        total++;
        if ({bus0.out_valid, busy0, done0} !== 3'b000) begin
            bad++;
            $display("FAIL t1_after got v=%b b=%b d=%b exp 0 0 0", bus0.out_valid, busy0, done0);
        end
        total++;
        if (det_fired !== 1'b1) begin
            bad++;
            $display("FAIL t1_detector got fired=%b exp 1", det_fired);
        end
    endtask

    task automatic test_backpressure();
        bus0.out_ready = 1'b0;
        rep0 = 8'd1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({bus0.out_valid, bus0.seq_idx} !== 3'b100 || bus0.out_data !== W[0]) begin
                bad++;
                $display("FAIL t2_hold%0d got v=%b i=%0d data=%h exp v=1 i=0 data=%h",
                         k, bus0.out_valid, bus0.seq_idx, bus0.out_data, W[0]);
            end
            if (k == 3) bus0.out_ready = 1'b1;
            @(negedge clk);
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if ({bus0.out_valid, bus0.seq_idx} !== {1'b1, 2'(i)} || bus0.out_data !== W[i]) begin
                bad++;
                $display("FAIL t2_word%0d got v=%b i=%0d data=%h exp v=1 i=%0d data=%h",
                         i, bus0.out_valid, bus0.seq_idx, bus0.out_data, i, W[i]);
            end
            @(negedge clk);
        end
        total++;
        if ({bus0.out_valid, busy0, done0} !== 3'b001) begin
            bad++;
            $display("FAIL t2_done got v=%b b=%b d=%b exp 0 0 1", bus0.out_valid, busy0, done0);
        end
        @(negedge clk);
    endtask

    task automatic test_rep_gap();
        int dones = 0;
        bus2.out_ready = 1'b1;
        rep2 = 8'd2;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        rep2 = 8'd5;  // mid-run change must be ignored
        for (int n = 0; n < 8; n++) begin
            total++;
            if ({bus2.out_valid, bus2.seq_idx, busy2} !== {1'b1, 2'(n % 4), 1'b1}
                || bus2.out_data !== W[n % 4]) begin
                bad++;
                $display("FAIL t3_word%0d got v=%b i=%0d b=%b data=%h exp v=1 i=%0d b=1 data=%h",
                         n, bus2.out_valid, bus2.seq_idx, busy2, bus2.out_data, n % 4, W[n % 4]);
            end
            @(negedge clk);
            if (n != 7) begin
                for (int g = 0; g < 2; g++) begin
                    total++;
                    if ({bus2.out_valid, busy2, done2} !== 3'b010) begin
                        bad++;
                        $display("FAIL t3_gap%0d_%0d got v=%b b=%b d=%b exp v=0 b=1 d=0",
                                 n, g, bus2.out_valid, busy2, done2);
                    end
                    @(negedge clk);
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (done2) dones++;
            if (c == 0) begin
                total++;
                if ({bus2.out_valid, busy2, done2} !== 3'b001) begin
                    bad++;
                    $display("FAIL t3_done got v=%b b=%b d=%b exp 0 0 1", bus2.out_valid, busy2, done2);
                end
            end
            @(negedge clk);
        end
        total++;
        if (dones != 1 || bus2.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL t3_tail got dones=%0d v=%b exp dones=1 v=0", dones, bus2.out_valid);
        end
    endtask

    task automatic test_rep_zero_busy_start();
        int extra = 0;
        bus0.out_ready = 1'b1;
        rep0 = 8'd0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({bus0.out_valid, bus0.seq_idx} !== {1'b1, 2'(i)} || bus0.out_data !== W[i]) begin
                bad++;
                $display("FAIL t4_word%0d got v=%b i=%0d data=%h exp v=1 i=%0d data=%h",
                         i, bus0.out_valid, bus0.seq_idx, bus0.out_data, i, W[i]);
            end
            start0 = (i == 1);
            @(negedge clk);
        end
        start0 = 1'b1;  // start while in DONE must also be ignored
        total++;
        if (done0 !== 1'b1) begin
            bad++;
            $display("FAIL t4_done got d=%b exp 1", done0);
        end
        @(negedge clk);
        start0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (bus0.out_valid || busy0) extra++;
            @(negedge clk);
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL t4_no_extra got busy_cycles=%0d exp 0", extra);
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        bus0.out_ready = 1'b1;
        rep0 = 8'd1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus0.seq_idx !== 2'd2 || bus0.out_data !== W[2]) begin
            bad++;
            $display("FAIL t5_w2 got i=%0d data=%h exp i=2 data=%h", bus0.seq_idx, bus0.out_data, W[2]);
        end
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        total++;
        if ({bus0.out_valid, bus0.seq_idx, busy0, done0} !== 5'b0 || bus0.out_data !== W[2]) begin
            bad++;
            $display("FAIL t5_abort got v=%b i=%0d b=%b d=%b data=%h exp v=0 i=0 b=0 d=0 data=%h",
                     bus0.out_valid, bus0.seq_idx, busy0, done0, bus0.out_data, W[2]);
        end
        for (int c = 0; c < 4; c++) begin
            if (done0) dones++;
            @(negedge clk);
        end
        total++;
        if (dones != 0 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL t5_quiet got dones=%0d b=%b exp 0 0", dones, busy0);
        end
        start0 = 1'b1;
        abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        abort0 = 1'b0;
        total++;
        if ({bus0.out_valid, busy0} !== 2'b00) begin
            bad++;
            $display("FAIL t5_abort_wins got v=%b b=%b exp 0 0", bus0.out_valid, busy0);
        end
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        total++;
        if ({bus0.out_valid, bus0.seq_idx, busy0} !== 4'b1001 || bus0.out_data !== W[0]) begin
            bad++;
            $display("FAIL t5_restart got v=%b i=%0d b=%b data=%h exp v=1 i=0 b=1 data=%h",
                     bus0.out_valid, bus0.seq_idx, busy0, bus0.out_data, W[0]);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_mid_gap();
        bus2.out_ready = 1'b1;
        rep2 = 8'd1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        total++;
        if ({bus2.out_valid, busy2} !== 2'b01) begin
            bad++;
            $display("FAIL t6_in_gap got v=%b b=%b exp v=0 b=1", bus2.out_valid, busy2);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({bus2.out_valid, bus2.seq_idx, busy2, done2} !== 5'b0 || bus2.out_data !== 128'd0) begin
            bad++;
            $display("FAIL t6_reset got v=%b i=%0d b=%b d=%b data=%h exp all zero",
                     bus2.out_valid, bus2.seq_idx, busy2, done2, bus2.out_data);
        end
        repeat (3) @(negedge clk);
        total++;
        if ({bus2.out_valid, busy2} !== 2'b00) begin
            bad++;
            $display("FAIL t6_stays_idle got v=%b b=%b exp 0 0", bus2.out_valid, busy2);
        end
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({bus2.out_valid, bus2.seq_idx} !== {1'b1, 2'(i)} || bus2.out_data !== W[i]) begin
                bad++;
                $display("FAIL t6_word%0d got v=%b i=%0d data=%h exp v=1 i=%0d data=%h",
                         i, bus2.out_valid, bus2.seq_idx, bus2.out_data, i, W[i]);
            end
            repeat ((i == 3) ? 1 : 3) @(negedge clk);
        end
        total++;
        if ({bus2.out_valid, busy2, done2} !== 3'b001) begin
            bad++;
            $display("FAIL t6_done got v=%b b=%b d=%b exp 0 0 1", bus2.out_valid, busy2, done2);
        end
        @(negedge clk);
    endtask

    initial begin
        W[0] = 128'h3243f6a8_885a308d_313198a2_e0370734;
        W[1] = 128'h00112233_44556677_8899aabb_ccddeeff;
        W[2] = 128'h0;
        W[3] = 128'h1;
        bus0.out_ready = 1'b0;
        bus2.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_pass();
        test_backpressure();
        test_rep_gap();
        test_rep_zero_busy_start();
        test_abort();
        test_reset_mid_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
